// File: rtl/qbus_master.sv
// qbus_master: native QBUS bus initiator for the vm2 bus.
// Turns a single local request into DATI, DATO, DATOB, DATIO or DATIOB cycles
// on the inverted multiplexed AD bus.
// Optional RPLY timeout: define QBUS_MASTER_TIMEOUT_EN.
module qbus_master #(
  parameter int unsigned ADDR_HOLD = 1,
  parameter int unsigned TOUT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_stb,
  input  logic        req_we,
  input  logic        req_rmw,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  input  logic [15:0] ad_in_n,
  output logic [15:0] ad_out_n,
  output logic        ad_oe,
  output logic        sync_n,
  output logic        din_n,
  output logic        dout_n,
  output logic        wtbt_n,
  input  logic        rply_n
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ASET  = 3'd1;
  localparam logic [2:0] S_ASYNC = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_RDEND = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_WREND = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  localparam logic [3:0] HOLD_LAST = 4'(ADDR_HOLD);

  logic [2:0]  state_q, state_d;
  logic        ph_q, ph_d;          // RD/WR sub-phase: 0 = turnaround/setup, 1 = strobe out
  logic [3:0]  hold_q, hold_d;
  logic        we_q, we_d, rmw_q, rmw_d, byte_q, byte_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        rply_m_q, rply_s_q;
  logic        busy_q, busy_d, ack_q, ack_d, err_q, err_d;
  logic [15:0] ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d, sync_q, sync_d, din_q, din_d, dout_q, dout_d, wtbt_q, wtbt_d;
  logic        capture, pure_wr, tout_hit;

  assign capture = (state_q == S_IDLE) && req_stb;
  assign pure_wr = we_q && !rmw_q;

  // Request attributes: take the new request in IDLE, otherwise hold.
  always_comb begin
    we_d    = capture ? req_we              : we_q;
    rmw_d   = capture ? (req_rmw && req_we) : rmw_q;
    byte_d  = capture ? req_byte            : byte_q;
    addr_d  = capture ? req_addr            : addr_q;
    wdata_d = capture ? req_wdata           : wdata_q;
  end

`ifdef QBUS_MASTER_TIMEOUT_EN
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic              wait_st;

  assign wait_st  = (state_q == S_RD) || (state_q == S_RDEND) ||
                    (state_q == S_WR) || (state_q == S_WREND);
  assign tout_hit = wait_st && (tout_q == '1);

  // Wait-cycle counter; restarts whenever the state changes.
  always_comb begin
    tout_d = '0;
    if (wait_st && (state_d == state_q) && !tout_hit) tout_d = tout_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (reset) tout_q <= '0;
    else       tout_q <= tout_d;
  end
`else
  logic [TOUT_W-1:0] tout_unused;
  assign tout_unused = '0;
  assign tout_hit    = 1'b0;
`endif

  // Bus cycle sequencer.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    hold_d  = hold_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE:  if (req_stb) state_d = S_ASET;
      S_ASET:  begin state_d = S_ASYNC; hold_d = 4'd1; end
      S_ASYNC: begin
        if (hold_q >= HOLD_LAST) begin
          state_d = pure_wr ? S_WR : S_RD;
          ph_d    = 1'b0;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_RD: begin
        if (!ph_q) ph_d = 1'b1;
        else if (!rply_s_q) begin
          rdata_d = ~ad_in_n;
          state_d = S_RDEND;
        end
      end
      S_RDEND: begin
        if (rply_s_q) begin
          state_d = rmw_q ? S_WR : S_FIN;
          ph_d    = 1'b0;
        end
      end
      S_WR: begin
        if (!ph_q) ph_d = 1'b1;
        else if (!rply_s_q) state_d = S_WREND;
      end
      S_WREND: if (rply_s_q) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
    if (tout_hit) begin
      state_d = S_IDLE;
      ph_d    = 1'b0;
      rdata_d = rdata_q;
    end
  end

  // Output decode from the next state, so every bus pin comes straight off a flop.
  always_comb begin
    ad_oe_d  = 1'b0;
    ad_out_d = '1;
    sync_d   = 1'b1;
    din_d    = 1'b1;
    dout_d   = 1'b1;
    wtbt_d   = 1'b1;
    busy_d   = (state_d != S_IDLE);
    ack_d    = (state_d == S_FIN);
    err_d    = tout_hit;
    case (state_d)
      S_ASET, S_ASYNC: begin
        ad_oe_d  = 1'b1;
        ad_out_d = ~addr_d;
        wtbt_d   = ~(we_d && !rmw_d);
        sync_d   = (state_d != S_ASYNC);
      end
      S_RD: begin
        sync_d = 1'b0;
        din_d  = ~ph_d;
      end
      S_RDEND: sync_d = 1'b0;
      S_WR, S_WREND: begin
        sync_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = ~wdata_d;
        wtbt_d   = ~byte_d;
        dout_d   = ~((state_d == S_WR) && ph_d);
      end
      default: ;
    endcase
  end

  // State, request and output registers; RPLY two-flop synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ph_q     <= 1'b0;
      hold_q   <= '0;
      we_q     <= 1'b0;
      rmw_q    <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rply_m_q <= 1'b1;
      rply_s_q <= 1'b1;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      ad_out_q <= '1;
      ad_oe_q  <= 1'b0;
      sync_q   <= 1'b1;
      din_q    <= 1'b1;
      dout_q   <= 1'b1;
      wtbt_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      hold_q   <= hold_d;
      we_q     <= we_d;
      rmw_q    <= rmw_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rply_m_q <= rply_n;
      rply_s_q <= rply_m_q;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      sync_q   <= sync_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      wtbt_q   <= wtbt_d;
    end
  end

  assign busy     = busy_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign ad_out_n = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign sync_n   = sync_q;
  assign din_n    = din_q;
  assign dout_n   = dout_q;
  assign wtbt_n   = wtbt_q;

endmodule

// File: tb/tb_qbus_master.sv
// tb_qbus_master: table-driven bench for qbus_master with a QBUS memory
// responder and an expected-result queue checked on every ack/err.
module tb_qbus_master;

  typedef struct {
    int          id;
    logic        we, rmw, byt;
    logic [15:0] addr, wdata, exp_rdata, exp_mem;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  logic        clk, reset, req_stb, req_we, req_rmw, req_byte;
  logic [15:0] req_addr, req_wdata, rdata, ad_in_n, ad_out_n;
  logic        busy, ack, err, ad_oe, sync_n, din_n, dout_n, wtbt_n, rply_n;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t sb_q[$];

  // Responder state
  logic [15:0] mem [0:1023];
  logic [15:0] lat_addr = '0;
  logic        resp_en = 1'b1;
  logic        mem_loaded = 1'b0;
  logic        resp_prev_sync = 1'b1;
  logic        mapped;

  qbus_master #(.ADDR_HOLD(1), .TOUT_W(4)) dut (
    .clk(clk), .reset(reset), .req_stb(req_stb), .req_we(req_we), .req_rmw(req_rmw),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .ack(ack), .err(err), .rdata(rdata), .ad_in_n(ad_in_n), .ad_out_n(ad_out_n),
    .ad_oe(ad_oe), .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n),
    .rply_n(rply_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input int id, input logic we, input logic rmw, input logic byt,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] exp_rdata, input logic [15:0] exp_mem,
                              input int exp_lat, input logic exp_err);
    vec_t v;
    v.id = id; v.we = we; v.rmw = rmw; v.byt = byt; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_mem = exp_mem; v.exp_lat = exp_lat; v.exp_err = exp_err;
    return v;
  endfunction

  // Memory responder: addresses below 160000 (octal) reply, everything above is unmapped.
  assign mapped  = (lat_addr < 16'o160000);
  assign rply_n  = ~(resp_en && mapped && !sync_n && (!din_n || !dout_n));
  assign ad_in_n = (!din_n && !sync_n && mapped) ? ~mem[lat_addr[10:1]] : '1;

  always @(negedge clk) begin
    logic [15:0] w;
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[16'o001000 >> 1] = 16'o123456;
      mem[16'o000400 >> 1] = 16'o000123;
      mem[16'o000100 >> 1] = 16'o000007;
      mem_loaded = 1'b1;
    end
    if (resp_prev_sync && !sync_n) lat_addr = ~ad_out_n;
    if (resp_en && mapped && !sync_n && !dout_n) begin
      w = ~ad_out_n;
      if (!wtbt_n) begin
        if (lat_addr[0]) mem[lat_addr[10:1]][15:8] = w[15:8];
        else             mem[lat_addr[10:1]][7:0]  = w[7:0];
      end else begin
        mem[lat_addr[10:1]] = w;
      end
    end
    resp_prev_sync = sync_n;
  end

  // Bus monitor and scoreboard
  logic        prev_sync = 1'b1, prev_oe = 1'b0, sync_seen = 1'b0;
  logic        saw_din = 1'b0, saw_dout = 1'b0, addr_wtbt = 1'b1, data_wtbt = 1'b1;
  logic [15:0] prev_ad = '1, addr_ad = '0;

  always @(negedge clk) begin
    vec_t e;
    check("din_dout_exclusive", {31'b0, din_n | dout_n}, 32'd1);
    check("oe_off_during_din", {31'b0, ad_oe & ~din_n}, 32'd0);
    if (sync_seen && busy && !ack) check("sync_held", {31'b0, sync_n}, 32'd0);
    if (prev_sync && !sync_n) begin
      check("addr_oe_before_sync", {31'b0, prev_oe}, 32'd1);
      check("addr_stable_at_sync", {16'b0, prev_ad}, {16'b0, ad_out_n});
      addr_ad   = ~ad_out_n;
      addr_wtbt = wtbt_n;
    end
    if (!sync_n) sync_seen = 1'b1;
    if (!din_n) begin
      check("din_before_dout", {31'b0, saw_dout}, 32'd0);
      saw_din = 1'b1;
    end
    if (!dout_n) begin
      saw_dout  = 1'b1;
      data_wtbt = wtbt_n;
    end
    if (ack || err) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {30'b0, ack, err}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("v%0d_ack", e.id), {31'b0, ack}, {31'b0, ~e.exp_err});
        check($sformatf("v%0d_err", e.id), {31'b0, err}, {31'b0, e.exp_err});
        if (!e.exp_err) begin
          check($sformatf("v%0d_rdata", e.id), {16'b0, rdata}, {16'b0, e.exp_rdata});
          check($sformatf("v%0d_mem", e.id), {16'b0, mem[e.addr[10:1]]}, {16'b0, e.exp_mem});
          check($sformatf("v%0d_addr_phase", e.id), {16'b0, addr_ad}, {16'b0, e.addr});
          check($sformatf("v%0d_addr_wtbt", e.id), {31'b0, addr_wtbt}, {31'b0, ~(e.we & ~e.rmw)});
          check($sformatf("v%0d_saw_din", e.id), {31'b0, saw_din}, {31'b0, ~e.we | e.rmw});
          check($sformatf("v%0d_saw_dout", e.id), {31'b0, saw_dout}, {31'b0, e.we});
          if (e.we) check($sformatf("v%0d_data_wtbt", e.id), {31'b0, data_wtbt}, {31'b0, ~e.byt});
        end
      end
    end
    if (!busy) begin
      sync_seen = 1'b0;
      saw_din   = 1'b0;
      saw_dout  = 1'b0;
    end
    prev_sync = sync_n;
    prev_oe   = ad_oe;
    prev_ad   = ad_out_n;
  end

  task automatic start_req(input vec_t v);
    @(negedge clk);
    req_we = v.we; req_rmw = v.rmw; req_byte = v.byt;
    req_addr = v.addr; req_wdata = v.wdata; req_stb = 1'b1;
    @(negedge clk);
    req_stb = 1'b0;
  endtask

  // Returns the number of clock edges after the request edge until ack/err.
  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (ack || err) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_released(input string tag);
    check({tag, "_sync_n"}, {31'b0, sync_n}, 32'd1);
    check({tag, "_din_n"},  {31'b0, din_n},  32'd1);
    check({tag, "_dout_n"}, {31'b0, dout_n}, 32'd1);
    check({tag, "_wtbt_n"}, {31'b0, wtbt_n}, 32'd1);
    check({tag, "_ad_oe"},  {31'b0, ad_oe},  32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs [10];

  initial begin
    vec_t        v;
    int          lat;
    bit          ok;
    logic [15:0] a;

    vecs[0] = mk(0, 0, 0, 0, 16'o001000, 16'o000000, 16'o123456, 16'o123456,  9, 0);
    vecs[1] = mk(1, 1, 0, 1, 16'o000401, 16'o177001, 16'o123456, 16'o177123,  9, 0);
    vecs[2] = mk(2, 0, 0, 0, 16'o000400, 16'o000000, 16'o177123, 16'o177123,  9, 0);
    vecs[3] = mk(3, 1, 1, 0, 16'o000100, 16'o000010, 16'o000007, 16'o000010, 16, 0);
    vecs[4] = mk(4, 0, 0, 0, 16'o000100, 16'o000000, 16'o000010, 16'o000010,  9, 0);
    vecs[5] = mk(5, 1, 0, 0, 16'o002000, 16'o052525, 16'o000010, 16'o052525,  9, 0);
    vecs[6] = mk(6, 1, 0, 1, 16'o002000, 16'o000377, 16'o000010, 16'o052777,  9, 0);
    vecs[7] = mk(7, 0, 0, 0, 16'o002000, 16'o000000, 16'o052777, 16'o052777,  9, 0);
    vecs[8] = mk(8, 1, 1, 1, 16'o000101, 16'o177000, 16'o000010, 16'o177010, 16, 0);
    vecs[9] = mk(9, 0, 0, 0, 16'o000100, 16'o000000, 16'o177010, 16'o177010,  9, 0);

    reset = 1'b1; req_stb = 1'b0; req_we = 1'b0; req_rmw = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_released("reset");
    check("reset_ad_out_n", {16'b0, ad_out_n}, 32'h0000_FFFF);
    check("reset_busy",  {31'b0, busy}, 32'd0);
    check("reset_ack",   {31'b0, ack},  32'd0);
    check("reset_err",   {31'b0, err},  32'd0);
    check("reset_rdata", {16'b0, rdata}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      sb_q.push_back(vecs[i]);
      start_req(vecs[i]);
      wait_done(lat, ok);
      check($sformatf("v%0d_done", i), {31'b0, ok}, 32'd1);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      if (!ok) pulse_reset();
    end

    // A request strobed while busy must be dropped.
    v = mk(10, 0, 0, 0, 16'o001000, 16'o000000, 16'o123456, 16'o123456, 9, 0);
    sb_q.push_back(v);
    start_req(v);
    @(negedge clk);
    req_we = 1'b1; req_rmw = 1'b0; req_byte = 1'b0;
    req_addr = 16'o003000; req_wdata = 16'o177777; req_stb = 1'b1;
    @(negedge clk);
    req_stb = 1'b0;
    wait_done(lat, ok);
    check("busy_ignore_done", {31'b0, ok}, 32'd1);
    repeat (3) @(negedge clk);
    a = 16'o003000;
    check("busy_ignore_mem", {16'b0, mem[a[10:1]]}, 32'd0);
    check("busy_ignore_idle", {31'b0, busy}, 32'd0);

    // Write to an unmapped address: no RPLY ever comes.
    v = mk(11, 1, 0, 0, 16'o160000, 16'o000123, 16'o000000, 16'o000000, 18, 1);
`ifdef QBUS_MASTER_TIMEOUT_EN
    sb_q.push_back(v);
    start_req(v);
    wait_done(lat, ok);
    check("tout_done", {31'b0, ok}, 32'd1);
    check("tout_latency", lat, v.exp_lat);
    check_released("tout");
    check("tout_busy", {31'b0, busy}, 32'd0);
    if (!ok) pulse_reset();
    repeat (5) @(negedge clk);
`else
    start_req(v);
    repeat (40) @(negedge clk);
    check("hang_busy",   {31'b0, busy},   32'd1);
    check("hang_dout_n", {31'b0, dout_n}, 32'd0);
    check("hang_err",    {31'b0, err},    32'd0);
    pulse_reset();
`endif

    // Reset while DIN is asserted, then a normal read.
    resp_en = 1'b0;
    v = mk(12, 0, 0, 0, 16'o001000, 16'o000000, 16'o123456, 16'o123456, 9, 0);
    start_req(v);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!din_n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_din_low", {31'b0, ok}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_released("abort");
    check("abort_busy",  {31'b0, busy},  32'd0);
    check("abort_rdata", {16'b0, rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resp_en = 1'b1;
    sb_q.delete();
    sb_q.push_back(v);
    start_req(v);
    wait_done(lat, ok);
    check("after_abort_done", {31'b0, ok}, 32'd1);
    check("after_abort_latency", lat, 9);
    repeat (4) @(negedge clk);
    check("queue_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qbus_master.md
# qbus_master

Synthesizable native-QBUS bus initiator for the 1801BM2 (vm2) environment. It converts a simple single-request local interface into QBUS DATI, DATO, DATOB and DATIO/DATIOB cycles on the inverted multiplexed AD bus, with SYNC/DIN/DOUT/WTBT strobes and RPLY handshaking. It is the initiator counterpart of the memory and terminal-register responders used on the vm2 bus, and serves as a DMA/test master driving those same slaves.

## Interface
- `ADDR_HOLD`, default 1: cycles the address stays driven after SYNC falls (1..15).
- `TOUT_W`, default 8: width of the RPLY timeout counter. Timeout occurs at 2^TOUT_W-1 cycles.
- `clk`  in  1  single system clock; every register is on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `req_stb`  in  1  start request, sampled only in IDLE.
- `req_we`  in  1  1 = write, 0 = read.
- `req_rmw`  in  1  with req_we=1: read-modify-write (DATIO); the write uses req_wdata.
- `req_byte`  in  1  byte write (DATOB/DATIOB); addr[0] selects the lane.
- `req_addr`  in  16  bus address, true polarity.
- `req_wdata`  in  16  write data, true polarity.
- `busy`  out  1  a request is in progress.
- `ack`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  one-cycle pulse on RPLY timeout.
- `rdata`  out  16  read data, true polarity, valid from ack and held until the next read.
- `ad_in_n`  in  16  inverted AD bus, sampled value.
- `ad_out_n`  out  16  inverted AD value to drive.
- `ad_oe`  out  1  AD output enable.
- `sync_n`, `din_n`, `dout_n`, `wtbt_n`  out  1 each  QBUS strobes, active-low.
- `rply_n`  in  1  reply, active-low, asynchronous.

## Operation
- RPLY path: `rply_n` passes through a 2-flop synchronizer. All decisions use the synchronized value `rply_s`.
- Request capture: in IDLE with `req_stb`=1, addr, data, we, rmw and byte are latched and `busy` is set. A `req_stb` that arrives while busy is ignored.
- States and transitions:
  - IDLE
  - ASET: 1 cycle.
    - `ad_oe`=1, `ad_out_n`=~addr.
    - `wtbt_n`=0 only for a pure write (we & ~rmw).
  - ASYNC: `sync_n`=0, address held for ADDR_HOLD cycles.
  - Then branch to RD or WR:
    - Read or rmw goes to RD.
    - Pure write goes to WR.
  - RD: 1 cycle turnaround with `ad_oe`=0, then `din_n`=0 and wait for `rply_s`=0.
    - On reply: rdata <= ~ad_in_n and `din_n`=1, then go to RDEND.
  - RDEND: wait for `rply_s`=1.
    - If rmw: go to WR.
    - Otherwise: go to FIN.
  - WR: `ad_oe`=1, `ad_out_n`=~wdata, `wtbt_n`=~byte.
    - 1 setup cycle, then `dout_n`=0 and wait for `rply_s`=0.
    - On reply: `dout_n`=1, then go to WREND.
  - WREND: wait for `rply_s`=1, then `ad_oe`=0 and go to FIN.
  - FIN: `sync_n`=1 and `wtbt_n`=1, pulse `ack`, clear `busy`, return to IDLE.
- SYNC stays asserted continuously through both halves of an rmw cycle.
- Exactly one of `ack` or `err` pulses per accepted request.
- Reset, including mid-cycle: on the next edge the block returns to IDLE and releases the bus.
  - `sync_n`, `din_n`, `dout_n`, `wtbt_n` = 1.
  - `ad_oe`=0, `ad_out_n`=16'hFFFF.
  - `busy`, `ack`, `err` = 0; rdata=0.
  - No ack or err is issued for the aborted request.

## Timing
- Minimum latency for a read with ADDR_HOLD=1 and a reply seen on the first DIN cycle, counted from the `req_stb` edge to the `ack` pulse:
  - 1 (ASET) + 1 (ASYNC) + 1 (turnaround) + 2 (sync) + 1 (RDEND) + 2 (negate sync) + 1 (FIN).
- Strobe ordering guarantees:
  - Address is valid at least 1 cycle before SYNC falls.
  - Data is valid at least 1 cycle before DOUT falls.
  - DIN and DOUT are never asserted together.
  - `ad_oe` is never 1 while `din_n`=0.
- A RPLY that is already low when DIN or DOUT is asserted is treated as an immediate reply.
- A RPLY pulse shorter than 2 cycles may be missed, which leads to a timeout.

## Configuration
- `QBUS_MASTER_TIMEOUT_EN` defined:
  - A TOUT_W-bit counter runs in each RPLY-wait state (RD, RDEND, WR, WREND) and clears on every state change.
  - On terminal count: negate all strobes, set `ad_oe`=0, pulse `err`, return to IDLE.
- Not defined: no counter is built and the block waits for RPLY indefinitely. `err` is tied to 0.

## Test plan
- DATI at 16'o001000, responder returns 16'o123456 → `ad_out_n`=~16'o001000 before SYNC; `rdata`=16'o123456 with a single `ack`.
- DATOB, addr 16'o000401, wdata 16'o177001 → `wtbt_n` low in the address phase and low in the data phase; only the high byte is written in the responder memory.
- DATIO, addr 16'o000100, read 16'o000007, write 16'o000010 → `sync_n` low throughout; `din_n` then `dout_n`; memory ends at 16'o000010; one `ack`.
- Write to an unmapped address 16'o160000 with TIMEOUT_EN and TOUT_W=4 → `err` after 15 wait cycles, strobes negated, no `ack`.
- Reset asserted while `din_n`=0 → all strobes high and `ad_oe`=0 on the next edge, `busy`=0, and the next request completes normally.
